// File: rtl/joystick_pkg.sv
// Shared types and the deflection classifier for the joystick step generator.
package joystick_pkg;

  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_DOWN = 2'd1,
    DIR_UP   = 2'd2
  } dir_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_LOAD = 2'd2
  } state_t;

  // Offsets within the deadzone (inclusive) produce no motion.
  function automatic dir_t classify(input int offset, input int deadzone);
    int mag;
    mag = (offset < 0) ? -offset : offset;
    if (mag <= deadzone) begin
      return DIR_NONE;
    end else if (offset > 0) begin
      return DIR_UP;
    end else begin
      return DIR_DOWN;
    end
  endfunction

endpackage

// File: rtl/rate_timer.sv
// Wrapping step-rate counter; tick_c is high once the count reaches period_m1_i.
module rate_timer #(
  parameter int unsigned TW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear_i,
  input  logic          en_i,
  input  logic [TW-1:0] period_m1_i,
  output logic          tick_c
);

  logic [TW-1:0] timer_q;
  logic [TW-1:0] timer_d;

  // >= rather than == so a shortened period fires on the next cycle.
  assign tick_c = (timer_q >= period_m1_i);

  always_comb begin
    timer_d = timer_q;
    if (clear_i) begin
      timer_d = '0;
    end else if (en_i) begin
      timer_d = tick_c ? '0 : timer_q + TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end

endmodule

// File: rtl/joystick_step_gen.sv
// Converts joystick axis samples into rate-limited step pulses for the sprite
// position counter, with bound stops and a one-cycle recentre load.
module joystick_step_gen
  import joystick_pkg::*;
#(
  parameter int unsigned ADC_BITS    = 10,
  parameter int unsigned POS_BITS    = 10,
  parameter int unsigned CENTER      = 512,
  parameter int unsigned DEADZONE    = 64,
  parameter int unsigned FAST_THRESH = 384,
  parameter int unsigned SLOW_DIV    = 2000000,
  parameter int unsigned FAST_DIV    = 500000,
  parameter int unsigned POS_MIN     = 0,
  parameter int unsigned POS_MAX     = 639,
  parameter int unsigned HOME        = 320
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sample_valid,
  input  logic [ADC_BITS-1:0] sample,
  output logic                sample_ready,
  input  logic                recentre,
  input  logic [POS_BITS-1:0] pos,
  output logic                cnt_load,
  output logic                cnt_enable,
  output logic                cnt_up,
  output logic [POS_BITS-1:0] cnt_d,
  output logic                moving
);

  localparam int unsigned OW = ADC_BITS + 1;
  localparam int unsigned TW = $clog2(SLOW_DIV);
  localparam logic [TW-1:0] SLOW_M1 = TW'(SLOW_DIV - 1);
  localparam logic [TW-1:0] FAST_M1 = TW'(FAST_DIV - 1);

  state_t state_q, state_d;
  dir_t   dir_q, dir_d;
  logic [TW-1:0] per_q, per_d;
  logic load_q, load_d;
  logic en_q, en_d;
  logic up_q, up_d;
  logic moving_q, moving_d;

  logic signed [OW-1:0] off_c;
  logic [OW-1:0]        mag_c;
  dir_t                 new_dir_c;
  logic [TW-1:0]        new_per_c;
  logic                 transfer_c;
  logic                 blocked_c;
  logic                 tick_c;
  logic                 tmr_clear_c;
  logic                 tmr_en_c;

  // Sample decode: signed offset from rest, direction and step period.
  assign off_c      = $signed({1'b0, sample}) - $signed(OW'(CENTER));
  assign mag_c      = off_c[OW-1] ? OW'(-off_c) : OW'(off_c);
  assign new_dir_c  = classify(int'(off_c), int'(DEADZONE));
  assign new_per_c  = (mag_c >= OW'(FAST_THRESH)) ? FAST_M1 : SLOW_M1;

  assign sample_ready = reset && (state_q != ST_LOAD);
  assign transfer_c   = sample_valid && sample_ready;

  assign blocked_c = ((dir_q == DIR_UP)   && (pos >= POS_BITS'(POS_MAX))) ||
                     ((dir_q == DIR_DOWN) && (pos <= POS_BITS'(POS_MIN)));

  rate_timer #(
    .TW(TW)
  ) u_rate_timer (
    .clk        (clk),
    .reset      (reset),
    .clear_i    (tmr_clear_c),
    .en_i       (tmr_en_c),
    .period_m1_i(per_q),
    .tick_c     (tick_c)
  );

  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    per_d       = per_q;
    load_d      = 1'b0;
    en_d        = 1'b0;
    up_d        = 1'b0;
    tmr_clear_c = 1'b0;
    tmr_en_c    = 1'b0;

    if (recentre) begin
      state_d     = ST_LOAD;
      dir_d       = DIR_NONE;
      load_d      = 1'b1;
      en_d        = 1'b1;
      tmr_clear_c = 1'b1;
    end else begin
      if (transfer_c) begin
        dir_d = new_dir_c;
        per_d = new_per_c;
      end
      unique case (state_q)
        ST_IDLE: begin
          tmr_clear_c = 1'b1;
          if (dir_q != DIR_NONE) begin
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          // A new sample that stops or reverses motion pre-empts this cycle's step.
          if ((transfer_c && (new_dir_c == DIR_NONE)) || (dir_q == DIR_NONE)) begin
            state_d     = ST_IDLE;
            tmr_clear_c = 1'b1;
          end else if (transfer_c && (new_dir_c != dir_q)) begin
            tmr_clear_c = 1'b1;
          end else begin
            tmr_en_c = 1'b1;
            if (tick_c && !blocked_c) begin
              en_d = 1'b1;
              up_d = (dir_q == DIR_UP);
            end
          end
        end
        ST_LOAD: begin
          state_d     = ST_IDLE;
          dir_d       = DIR_NONE;
          tmr_clear_c = 1'b1;
        end
        default: begin
          state_d     = ST_IDLE;
          dir_d       = DIR_NONE;
          tmr_clear_c = 1'b1;
        end
      endcase
    end

    moving_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      dir_q    <= DIR_NONE;
      per_q    <= SLOW_M1;
      load_q   <= 1'b0;
      en_q     <= 1'b0;
      up_q     <= 1'b0;
      moving_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      per_q    <= per_d;
      load_q   <= load_d;
      en_q     <= en_d;
      up_q     <= up_d;
      moving_q <= moving_d;
    end
  end

  assign cnt_load   = load_q;
  assign cnt_enable = en_q;
  assign cnt_up     = up_q;
  assign cnt_d      = POS_BITS'(HOME);
  assign moving     = moving_q;

endmodule

// File: tb/tb_joystick_step_gen.sv
// Scoreboard bench for joystick_step_gen with SLOW_DIV=8, FAST_DIV=4.
module tb_joystick_step_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       sample_valid;
  logic [9:0] sample;
  logic       sample_ready;
  logic       recentre;
  logic [9:0] pos;
  logic       cnt_load;
  logic       cnt_enable;
  logic       cnt_up;
  logic [9:0] cnt_d;
  logic       moving;

  logic       pos_set;
  logic [9:0] pos_set_v;

  int cyc   = 0;
  int total = 0;
  int bad   = 0;
  int t;

  typedef struct {
    int   cyc;
    logic up;
    logic load;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  joystick_step_gen #(
    .SLOW_DIV(8),
    .FAST_DIV(4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sample_valid(sample_valid),
    .sample      (sample),
    .sample_ready(sample_ready),
    .recentre    (recentre),
    .pos         (pos),
    .cnt_load    (cnt_load),
    .cnt_enable  (cnt_enable),
    .cnt_up      (cnt_up),
    .cnt_d       (cnt_d),
    .moving      (moving)
  );

  // Cycle count plus a model of the up/down position counter the block drives.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (pos_set) begin
      pos <= pos_set_v;
    end else if (cnt_enable) begin
      if (cnt_load) pos <= cnt_d;
      else          pos <= cnt_up ? pos + 10'd1 : pos - 10'd1;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int c, input logic u, input logic l);
    sb.push_back('{cyc: c, up: u, load: l});
  endtask

  task automatic drive(input logic [9:0] v);
    sample       = v;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Monitor: every counter pulse must match the next scoreboard entry.
  initial begin : monitor
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        e = sb.pop_front();
        total++;
        bad++;
        $display("FAIL missing_pulse: none by cycle %0d, required at cycle %0d", cyc, e.cyc);
      end
      if (cnt_enable) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_pulse: cnt_enable=1 at cycle %0d, required 0", cyc);
        end else begin
          e = sb.pop_front();
          check("pulse_cycle", cyc, e.cyc);
          check("pulse_up", int'(cnt_up), int'(e.up));
          check("pulse_load", int'(cnt_load), int'(e.load));
          if (e.load) check("pulse_d", int'(cnt_d), 320);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: bench still running at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin : stim
    reset        = 1'b0;
    sample_valid = 1'b0;
    sample       = 10'd512;
    recentre     = 1'b0;
    pos_set      = 1'b1;
    pos_set_v    = 10'd100;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_load", int'(cnt_load), 0);
    check("rst_enable", int'(cnt_enable), 0);
    check("rst_up", int'(cnt_up), 0);
    check("rst_moving", int'(moving), 0);
    check("rst_ready", int'(sample_ready), 0);
    reset = 1'b1;
    @(negedge clk);
    check("ready_after_rst", int'(sample_ready), 1);
    check("idle_moving", int'(moving), 0);

    // Centred stick: nothing for 50 cycles
    drive(10'd512);
    repeat (50) @(negedge clk);
    check("centre_moving", int'(moving), 0);
    pos_set = 1'b0;

    // Slow UP, then fast UP without clearing the timer
    t = cyc;
    drive(10'd700);
    check("run_entry_lag", int'(moving), 0);
    @(negedge clk);
    check("run_moving", int'(moving), 1);
    push(t + 10, 1'b1, 1'b0);
    push(t + 18, 1'b1, 1'b0);
    push(t + 26, 1'b1, 1'b0);
    wait_cyc(t + 26);
    drive(10'd1000);
    push(t + 30, 1'b1, 1'b0);
    push(t + 34, 1'b1, 1'b0);
    push(t + 38, 1'b1, 1'b0);
    wait_cyc(t + 38);
    check("fast_moving", int'(moving), 1);
    drive(10'd540);
    check("deadzone_idle", int'(moving), 0);
    check("pos_after_up", int'(pos), 106);

    // Fast DOWN from pos=1 stops at POS_MIN
    pos_set_v = 10'd1;
    pos_set   = 1'b1;
    @(negedge clk);
    pos_set = 1'b0;
    t = cyc;
    drive(10'd100);
    push(t + 6, 1'b0, 1'b0);
    repeat (20) @(negedge clk);
    check("min_moving", int'(moving), 1);
    check("min_pos", int'(pos), 0);

    // Reverse to fast UP at POS_MAX: no pulses
    pos_set_v = 10'd639;
    pos_set   = 1'b1;
    drive(10'd1000);
    pos_set = 1'b0;
    repeat (20) @(negedge clk);
    check("max_moving", int'(moving), 1);
    check("max_pos", int'(pos), 639);

    // Reversal at timer=5 restarts the period
    drive(10'd540);
    check("stop_idle", int'(moving), 0);
    pos_set_v = 10'd100;
    pos_set   = 1'b1;
    @(negedge clk);
    pos_set = 1'b0;
    t = cyc;
    drive(10'd700);
    push(t + 10, 1'b1, 1'b0);
    wait_cyc(t + 15);
    drive(10'd300);
    push(t + 24, 1'b0, 1'b0);
    push(t + 32, 1'b0, 1'b0);
    wait_cyc(t + 32);
    drive(10'd540);
    check("rev_stop_idle", int'(moving), 0);
    check("rev_pos", int'(pos), 99);

    // Recentre on a step terminal replaces the step with a load
    t = cyc;
    drive(10'd700);
    push(t + 10, 1'b1, 1'b0);
    wait_cyc(t + 17);
    recentre = 1'b1;
    push(t + 18, 1'b0, 1'b1);
    @(negedge clk);
    recentre = 1'b0;
    check("load_ready", int'(sample_ready), 0);
    check("load_d", int'(cnt_d), 320);
    @(negedge clk);
    check("post_load_load", int'(cnt_load), 0);
    check("post_load_enable", int'(cnt_enable), 0);
    check("post_load_moving", int'(moving), 0);
    check("post_load_ready", int'(sample_ready), 1);
    check("home_pos", int'(pos), 320);
    repeat (20) @(negedge clk);
    check("post_load_idle", int'(moving), 0);

    // Reset during LOAD drops the load at that edge
    recentre = 1'b1;
    push(cyc + 1, 1'b0, 1'b1);
    @(negedge clk);
    recentre = 1'b0;
    check("load2_load", int'(cnt_load), 1);
    reset = 1'b0;
    @(negedge clk);
    check("rst_in_load_load", int'(cnt_load), 0);
    check("rst_in_load_enable", int'(cnt_enable), 0);
    check("rst_in_load_moving", int'(moving), 0);
    check("rst_in_load_ready", int'(sample_ready), 0);
    reset = 1'b1;
    @(negedge clk);
    check("rel_ready", int'(sample_ready), 1);
    check("rel_moving", int'(moving), 0);
    repeat (30) @(negedge clk);
    check("rel_idle", int'(moving), 0);

    repeat (2) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
